// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_pkg
// Brief   : Shared state encoding, default geometry, block type and sizing
//           helpers for the main memory controller.
// Rev     : 1.0
// ============================================================================
package mem_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int BLOCK_SIZE_DEF = 16;
    localparam int MEM_BLOCKS_DEF = 256;
    localparam int ROW_BLOCKS_DEF = 8;

    localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE_DEF);
    localparam int INDEX_WIDTH  = $clog2(MEM_BLOCKS_DEF);
    localparam int ROW_WIDTH    = $clog2(ROW_BLOCKS_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } mem_state_e;

    typedef logic [BLOCK_SIZE_DEF-1:0][DATA_WIDTH_DEF-1:0] mem_block_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter holds latency-1, so a maximum latency of N needs clog2(N) bits.
    function automatic int cnt_width(input int max_lat);
        return (max_lat <= 2) ? 1 : $clog2(max_lat);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_block_array.sv
`default_nettype none
// ============================================================================
// Module : mem_block_array
// Brief  : Single-port block storage with write-enable and a registered read
//          port; a write also returns the written block on the read port.
// Rev    : 1.0
// ============================================================================
module mem_block_array
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 16,
    parameter int MEM_BLOCKS = 256,
    localparam int IDX_W     = $clog2(MEM_BLOCKS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  en,
    input  logic                                  we,
    input  logic [IDX_W-1:0]                      addr,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] wdata,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rdata
);

    // Contents start at zero and survive rst_n.
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem [MEM_BLOCKS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/main_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module : main_memory_ctrl
// Brief  : Block-granular backing store behind the L2 with counter-modelled
//          latency. Define MAIN_MEMORY_ROW_BUFFER_EN for open-row fast hits.
// Rev    : 1.0
// ============================================================================
module main_memory_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int BLOCK_SIZE      = 16,
    parameter int MEM_BLOCKS      = 256,
    parameter int READ_LATENCY    = 10,
    parameter int WRITE_LATENCY   = 10,
    parameter int ROW_BLOCKS      = 8,
    parameter int ROW_HIT_LATENCY = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ADDR_WIDTH-1:0]                 mem_addr,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_wdata,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_rdata,
    input  logic                                  mem_read,
    input  logic                                  mem_write,
    output logic                                  mem_ready,
    output logic                                  mem_hit
);

    localparam int OFF_W = $clog2(BLOCK_SIZE);
    localparam int IDX_W = $clog2(MEM_BLOCKS);
    localparam int CNT_W = cnt_width(max3(READ_LATENCY, WRITE_LATENCY, ROW_HIT_LATENCY));

    localparam logic [1:0] ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] ST_ACCESS  = 2'(ACCESS);
    localparam logic [1:0] ST_RESPOND = 2'(RESPOND);

    logic [1:0]                            state;
    logic [CNT_W-1:0]                      cnt;
    logic                                  op_write;
    logic [IDX_W-1:0]                      op_idx;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] op_wdata;

    logic [IDX_W-1:0] req_idx;
    logic             req_valid;
    logic             req_hit;
    logic [CNT_W-1:0] req_cnt;
    logic             access_done;
    logic             unused_addr_bits;

    assign req_idx     = mem_addr[OFF_W +: IDX_W];
    assign req_valid   = mem_read | mem_write;
    assign access_done = (state == ST_ACCESS) && (cnt == '0);

    assign unused_addr_bits = ^{mem_addr[ADDR_WIDTH-1:OFF_W+IDX_W], mem_addr[OFF_W-1:0]};

`ifdef MAIN_MEMORY_ROW_BUFFER_EN
    localparam int ROW_W    = $clog2(ROW_BLOCKS);
    localparam int ROWNUM_W = IDX_W - ROW_W;

    logic [ROWNUM_W-1:0] open_row;
    logic                row_valid;
    logic                op_hit;

    assign req_hit = row_valid && (open_row == req_idx[IDX_W-1:ROW_W]);

    // Open row follows every accepted request, hit or miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_valid <= 1'b0;
            open_row  <= '0;
            op_hit    <= 1'b0;
        end else if ((state == ST_IDLE) && req_valid) begin
            row_valid <= 1'b1;
            open_row  <= req_idx[IDX_W-1:ROW_W];
            op_hit    <= req_hit;
        end
    end

    assign mem_hit = (state == ST_RESPOND) && op_hit;
`else
    logic unused_row_cfg;

    assign unused_row_cfg = (ROW_BLOCKS > 0);
    assign req_hit        = 1'b0;
    assign mem_hit        = 1'b0;
`endif

    // A simultaneous read+write is serviced as a write.
    always_comb begin
        req_cnt = mem_write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
        if (req_hit) begin
            req_cnt = CNT_W'(ROW_HIT_LATENCY - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_write <= 1'b0;
            op_idx   <= '0;
            op_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_write <= mem_write;
                        op_idx   <= req_idx;
                        op_wdata <= mem_wdata;
                        cnt      <= req_cnt;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        state <= ST_RESPOND;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESPOND: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    assign mem_ready = (state == ST_RESPOND);

    // Storage is touched only on the edge entering RESPOND, so an aborted
    // access never commits.
    mem_block_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE),
        .MEM_BLOCKS (MEM_BLOCKS)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (access_done),
        .we    (op_write),
        .addr  (op_idx),
        .wdata (op_wdata),
        .rdata (mem_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_main_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_main_memory_ctrl
// Brief  : Directed and randomized checks of main_memory_ctrl against an
//          array-based reference model (row buffer modelled when enabled).
// Rev    : 1.0
// ============================================================================
module tb_main_memory_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BS = 16;
    localparam int NB = 256;
    localparam int RL = 10;
    localparam int WL = 10;
    localparam int RB = 8;
    localparam int HL = 2;
    localparam int W  = BS * DW;

`ifdef MAIN_MEMORY_ROW_BUFFER_EN
    localparam bit ROW_EN = 1'b1;
`else
    localparam bit ROW_EN = 1'b0;
`endif

    typedef logic [BS-1:0][DW-1:0] blk_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    blk_t          mem_wdata = '0;
    blk_t          mem_rdata;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic          mem_ready;
    logic          mem_hit;

    always #5 clk = ~clk;

    main_memory_ctrl #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .BLOCK_SIZE      (BS),
        .MEM_BLOCKS      (NB),
        .READ_LATENCY    (RL),
        .WRITE_LATENCY   (WL),
        .ROW_BLOCKS      (RB),
        .ROW_HIT_LATENCY (HL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_ready (mem_ready),
        .mem_hit   (mem_hit)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    blk_t ref_mem [NB];
    bit   row_valid = 1'b0;
    int   open_row = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int blk_index(input logic [AW-1:0] a);
        return int'((a / BS) % NB);
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int w = 0; w < BS; w++) b[w] = $urandom;
        return b;
    endfunction

    // Drive one request from IDLE and check latency, data, hit and pulse width.
    task automatic run_op(input string tag, input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input blk_t data, input bit withdraw, input bit hold_after);
        int   idx;
        int   lat;
        int   n;
        int   wd_at;
        bit   hit;
        blk_t exp;
        idx = blk_index(addr);
        hit = ROW_EN && row_valid && (idx / RB == open_row);
        lat = hit ? HL : (wr ? WL : RL);
        row_valid = 1'b1;
        open_row  = idx / RB;
        if (wr) ref_mem[idx] = data;
        exp   = ref_mem[idx];
        wd_at = (withdraw && lat > 1) ? $urandom_range(1, lat - 1) : 0;

        mem_addr = addr; mem_wdata = data; mem_read = rd; mem_write = wr;
        @(posedge clk); #1;
        n = 0;
        for (int k = 1; k <= lat + 8; k++) begin
            if (k == wd_at) begin
                mem_read = 1'b0; mem_write = 1'b0;
                mem_addr = $urandom; mem_wdata = rand_blk();
            end
            @(posedge clk); #1;
            if (mem_ready) begin
                n = k;
                break;
            end
        end
        check($sformatf("%s.lat", tag), W'(n), W'(lat));
        if (n != 0) begin
            check($sformatf("%s.rdata", tag), mem_rdata, exp);
            check($sformatf("%s.hit", tag), W'(mem_hit), W'(hit));
        end
        if (!hold_after) begin
            mem_read = 1'b0; mem_write = 1'b0;
        end
        @(posedge clk); #1;
        check($sformatf("%s.pulse", tag), W'({mem_ready, mem_hit}), W'(2'b00));
        if (n != 0) check($sformatf("%s.hold", tag), mem_rdata, exp);
    endtask

    initial begin
        blk_t d;
        bit   seen;
        int   idx;
        int   r;
        logic [AW-1:0] a;

        for (int i = 0; i < NB; i++) ref_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset.ready", W'(mem_ready), W'(1'b0));
        check("reset.hit", W'(mem_hit), W'(1'b0));
        check("reset.rdata", mem_rdata, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int w = 0; w < BS; w++) d[w] = DW'(32'hA0 + w);
        run_op("wr40", 1'b0, 1'b1, 32'h0000_0040, d, 1'b0, 1'b0);
        run_op("rd40", 1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0);

        run_op("wr1040", 1'b0, 1'b1, 32'h0000_1040, rand_blk(), 1'b0, 1'b0);
        run_op("alias40", 1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0);

        for (int w = 0; w < BS; w++) d[w] = DW'(32'h55);
        run_op("both80", 1'b1, 1'b1, 32'h0000_0080, d, 1'b0, 1'b0);
        run_op("rd80", 1'b1, 1'b0, 32'h0000_0080, '0, 1'b0, 1'b0);

        // Abort a write to 0xC0 five cycles into ACCESS.
        for (int w = 0; w < BS; w++) d[w] = DW'(32'h77);
        mem_addr = 32'h0000_00C0; mem_wdata = d; mem_write = 1'b1;
        @(posedge clk); #1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            seen |= mem_ready;
        end
        rst_n = 1'b0; mem_write = 1'b0;
        #1;
        check("rst.noready", W'(seen), W'(1'b0));
        check("rst.ready", W'(mem_ready), W'(1'b0));
        check("rst.hit", W'(mem_hit), W'(1'b0));
        check("rst.rdata", mem_rdata, '0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        row_valid = 1'b0;
        @(posedge clk); #1;
        run_op("rst.rdC0", 1'b1, 1'b0, 32'h0000_00C0, '0, 1'b0, 1'b0);

        run_op("b2b.first", 1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b1);
        run_op("b2b.second", 1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0);

        run_op("row.rd40", 1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0);
        run_op("row.rd50", 1'b1, 1'b0, 32'h0000_0050, '0, 1'b0, 1'b0);
        run_op("row.rd400", 1'b1, 1'b0, 32'h0000_0400, '0, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            idx = $urandom_range(0, 31);
            a   = ($urandom & 32'hFFFF_F000) | AW'(idx << 4) | AW'($urandom_range(0, 15));
            r   = $urandom_range(0, 3);
            run_op($sformatf("rnd%0d", t), (r <= 1) || (r == 3), (r >= 2), a, rand_blk(),
                   ($urandom_range(0, 3) == 0), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/main_memory_ctrl.md
Name: main_memory_ctrl

Overview:
- Backing-store controller directly downstream of the L2 cache. It serves whole-block reads and writes on the L2 memory interface.
- Request protocol: level-held mem_read/mem_write, a one-cycle mem_ready completion pulse, and an optional mem_hit open-row indication.
- Models main-memory latency with a counter-driven FSM over an internal block array.

Parameters:
- DATA_WIDTH, 32, bits per word
- ADDR_WIDTH, 32, address width
- BLOCK_SIZE, 16, words per block (must equal L2 BLOCK_SIZE)
- MEM_BLOCKS, 256, blocks of storage (power of two)
- READ_LATENCY, 10, cycles from accept to mem_ready for reads (>=1)
- WRITE_LATENCY, 10, cycles from accept to mem_ready for writes (>=1)
- ROW_BLOCKS, 8, blocks per row (used only with ROW_BUFFER_EN)
- ROW_HIT_LATENCY, 2, latency on an open-row access (>=1, used only with ROW_BUFFER_EN)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- mem_addr  input  ADDR_WIDTH  byte address from L2
- mem_wdata  input  BLOCK_SIZE x DATA_WIDTH  block to write (L2 mem_data_out)
- mem_rdata  output  BLOCK_SIZE x DATA_WIDTH  block read (L2 mem_data_in)
- mem_read  input  1  read request, held until completion
- mem_write  input  1  write request, held until completion
- mem_ready  output  1  one-cycle completion pulse
- mem_hit  output  1  open-row completion, only ever high together with mem_ready

Behaviour:
- Clocking and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, mem_ready=0, mem_hit=0, mem_rdata=0, counter=0, row buffer invalid.
- Storage array: all-zero at elaboration; not cleared by rst_n.
- Block index: mem_addr[log2(BLOCK_SIZE) +: log2(MEM_BLOCKS)]. Upper address bits are ignored (aliases wrap). Low offset bits are ignored.
- State IDLE:
  - If mem_read or mem_write is high at an edge, latch op, index and mem_wdata.
  - Load counter with latency-1 and go to ACCESS.
  - If both mem_read and mem_write are high, treat as a write.
- State ACCESS:
  - Decrement the counter each cycle. At 0, go to RESPOND.
  - Latched request fields are frozen; input changes during ACCESS are ignored.
- State RESPOND (one cycle):
  - mem_ready=1.
  - Read: mem_rdata is loaded with array[index] on the edge entering RESPOND.
  - Write: array[index] is updated on the edge entering RESPOND, and mem_rdata is loaded with the written block.
  - Next state is always IDLE; mem_ready returns to 0.
- Latency: with accept at edge E0, mem_ready is high in the cycle after edge E0+LAT.
- mem_rdata holds its value between completions.
- Request handshake:
  - The requester drops mem_read/mem_write on the edge that samples mem_ready.
  - A request still high in IDLE after RESPOND is accepted as a new request (back-to-back legal).
  - A request withdrawn during ACCESS still completes and still pulses mem_ready.
- Reset mid-ACCESS aborts the operation. A pending write is not committed and no mem_ready is produced.
- mem_rdata is registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: MAIN_MEMORY_ROW_BUFFER_EN.
- When defined:
  - Track open_row = index / ROW_BLOCKS and a valid bit; both are updated at every accept.
  - Accept with valid && same row: use ROW_HIT_LATENCY, and mem_hit=1 in the RESPOND cycle.
  - Any other accept: use the op's normal latency, and mem_hit=0.
  - Reset invalidates the row.
- When undefined:
  - mem_hit is tied 0.
  - Latencies are always READ_LATENCY/WRITE_LATENCY.
  - No row register is built.

Decomposition:
- Package mem_pkg: state enum (IDLE, ACCESS, RESPOND), derived localparams (OFFSET_WIDTH, INDEX_WIDTH, ROW_WIDTH), block typedef (BLOCK_SIZE x DATA_WIDTH).
- Sub-module mem_block_array: synchronous single-port block storage with a write-enable and registered read. The FSM and row tracking stay in main_memory_ctrl.

Test Plan:
- Write then read:
  - Write 0x0000_0040 with words 0xA0..0xAF, then read 0x0000_0040.
  - Expect mem_ready exactly 10 cycles after each accept, and mem_rdata words 0xA0..0xAF.
- Alias wrap:
  - Write 0x0000_1040; MEM_BLOCKS=256 and BLOCK_SIZE=16 give index 4.
  - Read 0x0000_0040 and expect the same data.
- Simultaneous request:
  - mem_read=mem_write=1 at 0x80 with data 0x55.
  - Expect write latency, the array updated, and mem_rdata=0x55 at mem_ready.
- Reset mid-access:
  - Write 0xC0 = 0x77, then assert rst_n=0 at cycle 5 of ACCESS.
  - Expect no mem_ready, outputs 0, and a later read of 0xC0 returning the prior contents (0).
- Back-to-back:
  - Hold mem_read through RESPOND on 0x40.
  - Expect a second accept in the following IDLE and a second mem_ready 10 cycles later.
- With MAIN_MEMORY_ROW_BUFFER_EN:
  - Read 0x40, then 0x50 (same row). The second completes in 2 cycles with mem_hit=mem_ready=1.
  - Then read 0x400 (new row): 10 cycles, mem_hit=0.
